// File: rtl/abft_pkg.sv
// Shared types and sizing for the ABFT sequencing controller.
package abft_pkg;
  localparam int ROWS      = 4;
  localparam int ROW_W     = 2;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_CHECK,
    S_READ,
    S_DONE
  } abft_state_e;
endpackage

// File: rtl/abft_seq_ctrl_if.sv
// Control/handshake bundle between the ABFT controller (slave) and its environment (master).
// Both row streams transfer on a cycle where valid and ready are high together; ready never waits on valid.
interface abft_seq_ctrl_if;
  import abft_pkg::*;

  logic                 start;
  logic                 src_valid;
  logic                 src_ready;
  logic                 dp_clr;
  logic                 dp_load;
  logic [ROW_W-1:0]     dp_row;
  logic                 dp_error;
  logic [ROW_W-1:0]     dp_sel;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [1:0]           retry_cnt;
  logic [ERR_CNT_W-1:0] err_total;
  abft_state_e          dbg_state;

  modport master (
    output start, src_valid, dp_error, out_ready,
    input  src_ready, dp_clr, dp_load, dp_row, dp_sel, out_valid,
           busy, done, fail, retry_cnt, err_total, dbg_state
  );

  modport slave (
    input  start, src_valid, dp_error, out_ready,
    output src_ready, dp_clr, dp_load, dp_row, dp_sel, out_valid,
           busy, done, fail, retry_cnt, err_total, dbg_state
  );
endinterface

// File: rtl/abft_beat_cnt.sv
// Row-index counter with clear (priority over enable) and last-row flag.
module abft_beat_cnt
  import abft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [ROW_W-1:0] cnt_o,
  output logic             term_o
);
  logic [ROW_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == ROW_W'(ROWS - 1));
endmodule

// File: rtl/abft_seq_ctrl.sv
// ABFT batch sequencer: clear, load 4 rows, checksum check (optional retry), read out 4 rows.
// Retry-on-error path is compiled in only when ABFT_RETRY_EN is defined.
module abft_seq_ctrl
  import abft_pkg::*;
#(
  parameter int CHECK_LAT = 1,
  parameter int MAX_RETRY = 2
) (
  input logic            clk,
  input logic            rst,
  abft_seq_ctrl_if.slave ctrl_if
);
`ifdef ABFT_RETRY_EN
  localparam bit RetryOn = 1'b1;
`else
  localparam bit RetryOn = 1'b0;
`endif
  localparam logic [1:0] ChkLast = 2'(CHECK_LAT - 1);

  abft_state_e          state_q, state_d;
  logic [1:0]           chk_cnt_q, chk_cnt_d;
  logic [1:0]           retry_q, retry_d;
  logic                 fail_q, fail_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic             cnt_clr, beat_en, beat_term, row_en, row_term;
  logic [ROW_W-1:0] beat_cnt, row_cnt;
  logic             retry_ok;

  assign ctrl_if.src_ready = (state_q == S_LOAD);
  assign ctrl_if.dp_load   = ctrl_if.src_valid & ctrl_if.src_ready;
  assign ctrl_if.dp_clr    = (state_q == S_CLEAR);
  assign ctrl_if.out_valid = (state_q == S_READ);
  assign ctrl_if.done      = (state_q == S_DONE);
  assign ctrl_if.busy      = (state_q != S_IDLE);
  assign ctrl_if.dp_row    = beat_cnt;
  assign ctrl_if.dp_sel    = row_cnt;
  assign ctrl_if.fail      = fail_q;
  assign ctrl_if.retry_cnt = retry_q;
  assign ctrl_if.err_total = err_q;
  assign ctrl_if.dbg_state = state_q;

  assign cnt_clr  = (state_q == S_CLEAR);
  assign beat_en  = ctrl_if.dp_load;
  assign row_en   = ctrl_if.out_valid & ctrl_if.out_ready;
  // Without retry support retry_ok is constant 0, so retry_q never leaves 0.
  assign retry_ok = RetryOn && (int'(retry_q) < MAX_RETRY);

  abft_beat_cnt u_beat_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(beat_en),
    .cnt_o(beat_cnt), .term_o(beat_term)
  );

  abft_beat_cnt u_row_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(row_en),
    .cnt_o(row_cnt), .term_o(row_term)
  );

  always_comb begin
    state_d   = state_q;
    chk_cnt_d = chk_cnt_q;
    retry_d   = retry_q;
    fail_d    = fail_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (ctrl_if.start) begin
        state_d = S_CLEAR;
        fail_d  = 1'b0;
        retry_d = '0;
      end
      S_CLEAR: state_d = S_LOAD;
      S_LOAD: if (ctrl_if.dp_load && beat_term) begin
        state_d   = S_CHECK;
        chk_cnt_d = '0;
      end
      S_CHECK: begin
        if (chk_cnt_q != ChkLast) begin
          chk_cnt_d = chk_cnt_q + 2'd1;
        end else if (!ctrl_if.dp_error) begin
          state_d = S_READ;
        end else begin
          err_d = (err_q == '1) ? err_q : err_q + 1'b1;
          if (retry_ok) begin
            retry_d = retry_q + 2'd1;
            state_d = S_CLEAR;
          end else begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_READ: if (row_en && row_term) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      chk_cnt_q <= '0;
      retry_q   <= '0;
      fail_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      chk_cnt_q <= chk_cnt_d;
      retry_q   <= retry_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_abft_seq_ctrl.sv
// Directed bench for abft_seq_ctrl; expectations adapt to whether ABFT_RETRY_EN is defined.
module tb_abft_seq_ctrl;
  import abft_pkg::*;

  logic clk;
  logic rst;
  abft_seq_ctrl_if bus ();

  abft_seq_ctrl #(.CHECK_LAT(1), .MAX_RETRY(2)) dut (
    .clk(clk), .rst(rst), .ctrl_if(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_err    = 0;

  // scoreboard: expected dp_row per load and dp_sel per readout handshake
  logic [ROW_W-1:0] exp_load_q[$];
  logic [ROW_W-1:0] exp_read_q[$];

  int sv_a = -1, sv_b = -1, or_a = -1, or_b = -1, err_mode = 0;
  int r_done, r_first_load, r_last_load, r_first_read, r_last_read;
  int n_clr, n_load, n_read, n_ov, n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_rows(input int attempts, input bit do_read);
    for (int a = 0; a < attempts; a++)
      for (int r = 0; r < ROWS; r++) exp_load_q.push_back(ROW_W'(r));
    if (do_read)
      for (int r = 0; r < ROWS; r++) exp_read_q.push_back(ROW_W'(r));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dp_clr"},    bus.dp_clr,    0);
    chk({tag, "_dp_load"},   bus.dp_load,   0);
    chk({tag, "_src_ready"}, bus.src_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_done"},      bus.done,      0);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_fail"},      bus.fail,      0);
    chk({tag, "_retry_cnt"}, bus.retry_cnt, 0);
    chk({tag, "_err_total"}, bus.err_total, 0);
    chk({tag, "_dp_row"},    bus.dp_row,    0);
    chk({tag, "_dp_sel"},    bus.dp_sel,    0);
  endtask

  // driver: caller is aligned 1 time unit after a rising edge; cycle 0 is the start cycle
  task automatic run_batch(input int max_cyc);
    bit               seen_done;
    logic [ROW_W-1:0] e;
    r_done = -1; r_first_load = -1; r_last_load = -1; r_first_read = -1; r_last_read = -1;
    n_clr = 0; n_load = 0; n_read = 0; n_ov = 0; n_chk = 0;
    seen_done = 1'b0;
    bus.start     = 1'b1;
    bus.src_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.dp_error  = (err_mode != 0);
    for (int k = 0; k < max_cyc && !seen_done; k++) begin
      @(negedge clk);
      if (bus.dp_clr) n_clr++;
      if (bus.dp_load) begin
        if (r_first_load < 0) r_first_load = k;
        r_last_load = k;
        n_load++;
        chk("load_q_avail", exp_load_q.size() != 0, 1);
        if (exp_load_q.size() != 0) begin
          e = exp_load_q.pop_front();
          chk("dp_row", bus.dp_row, e);
        end
      end
      if (bus.out_valid) n_ov++;
      if (bus.out_valid && bus.out_ready) begin
        if (r_first_read < 0) r_first_read = k;
        r_last_read = k;
        n_read++;
        chk("read_q_avail", exp_read_q.size() != 0, 1);
        if (exp_read_q.size() != 0) begin
          e = exp_read_q.pop_front();
          chk("dp_sel", bus.dp_sel, e);
        end
      end
      if (bus.dbg_state == S_CHECK) n_chk++;
      if (bus.done) begin
        r_done    = k;
        seen_done = 1'b1;
      end
      chk("excl", 32'($countones({bus.dp_clr, bus.dp_load, bus.out_valid, bus.done}) <= 1), 1);
      if (k >= sv_a && k <= sv_b) begin
        chk("stall_no_load", bus.dp_load, 0);
        chk("stall_dp_row", bus.dp_row, 1);
        chk("stall_src_ready", bus.src_ready, 1);
      end
      if (k >= or_a && k <= or_b) begin
        chk("hold_out_valid", bus.out_valid, 1);
        chk("hold_dp_sel", bus.dp_sel, 2);
      end
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.src_valid = !((k + 1) >= sv_a && (k + 1) <= sv_b);
      bus.out_ready = !((k + 1) >= or_a && (k + 1) <= or_b);
      bus.dp_error  = (err_mode == 2) || (err_mode == 1 && n_chk == 0);
    end
    chk("batch_done_seen", seen_done, 1);
    chk("load_q_drained", exp_load_q.size(), 0);
    chk("read_q_drained", exp_read_q.size(), 0);
    exp_load_q.delete();
    exp_read_q.delete();
    bus.src_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dp_error  = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.src_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.dp_error  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset_state", bus.dbg_state, S_IDLE);
    rst = 1'b1;

    // clean batch, started on the first edge after reset release
    push_rows(1, 1);
    run_batch(40);
    chk("clean_first_load", r_first_load, 2);
    chk("clean_last_load",  r_last_load,  5);
    chk("clean_first_read", r_first_read, 7);
    chk("clean_last_read",  r_last_read,  10);
    chk("clean_done",       r_done,       11);
    chk("clean_n_clr",      n_clr,        1);
    chk("clean_fail",       bus.fail,     0);
    chk("clean_busy_after", bus.busy,     0);

    // source stall on beat 1 for 3 cycles
    sv_a = 3; sv_b = 5;
    push_rows(1, 1);
    run_batch(40);
    sv_a = -1; sv_b = -1;
    chk("stall_load_span", r_last_load - r_first_load + 1, 7);
    chk("stall_n_load",    n_load, 4);
    chk("stall_done",      r_done, 14);

    // consumer stall on readout row 2 for 4 cycles
    or_a = 9; or_b = 12;
    push_rows(1, 1);
    run_batch(40);
    or_a = -1; or_b = -1;
    chk("oready_last_read", r_last_read, 14);
    chk("oready_done",      r_done,      15);
    chk("oready_n_ov",      n_ov,        8);

    // checksum error on the first check only
    err_mode = 1;
`ifdef ABFT_RETRY_EN
    push_rows(2, 1);
    run_batch(60);
    chk("err1_n_chk",     n_chk,         2);
    chk("err1_n_clr",     n_clr,         2);
    chk("err1_retry_cnt", bus.retry_cnt, 1);
    chk("err1_fail",      bus.fail,      0);
    chk("err1_n_read",    n_read,        4);
    chk("err1_done",      r_done,        17);
`else
    push_rows(1, 0);
    run_batch(60);
    chk("err1_n_chk",     n_chk,         1);
    chk("err1_retry_cnt", bus.retry_cnt, 0);
    chk("err1_fail",      bus.fail,      1);
    chk("err1_n_ov",      n_ov,          0);
    chk("err1_done",      r_done,        7);
`endif
    chk("err1_err_total", bus.err_total, 1);

    // checksum error on every check
    err_mode = 2;
`ifdef ABFT_RETRY_EN
    push_rows(3, 0);
    run_batch(80);
    chk("errall_n_chk",     n_chk,         3);
    chk("errall_retry_cnt", bus.retry_cnt, 2);
    chk("errall_done",      r_done,        19);
    chk("errall_err_total", bus.err_total, 4);
`else
    push_rows(1, 0);
    run_batch(80);
    chk("errall_n_chk",     n_chk,         1);
    chk("errall_retry_cnt", bus.retry_cnt, 0);
    chk("errall_done",      r_done,        7);
    chk("errall_err_total", bus.err_total, 2);
`endif
    chk("errall_fail", bus.fail, 1);
    chk("errall_n_ov", n_ov,     0);
    err_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("fail_held", bus.fail, 1);

    // reset asserted mid-readout at row 1
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.src_valid = 1'b1;
    bus.out_ready = 1'b1;
    chk("restart_fail_cleared", bus.fail,   0);
    chk("restart_clr",          bus.dp_clr, 1);
    repeat (7) @(posedge clk);
    #1;
    chk("midread_out_valid", bus.out_valid, 1);
    chk("midread_dp_sel",    bus.dp_sel,    1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    chk("midreset_state", bus.dbg_state, S_IDLE);
    bus.src_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    push_rows(1, 1);
    run_batch(40);
    chk("post_reset_done",      r_done,        11);
    chk("post_reset_n_read",    n_read,        4);
    chk("post_reset_fail",      bus.fail,      0);
    chk("post_reset_err_total", bus.err_total, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/abft_seq_ctrl.md
ABFT_SEQ_CTRL -- requirements
Module: abft_seq_ctrl

Interface
REQ-001 Parameter CHECK_LAT, default 1, cycles between last row load and checksum-error sample (range 1..4).
REQ-002 Parameter MAX_RETRY, default 2, maximum batch reloads after a checksum error (range 0..3).
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  begin one batch; sampled only in IDLE.
REQ-006 src_valid  in  1  source presents one row (col/row checksums + product word) on datapath inputs.
REQ-007 src_ready  out  1  controller accepts a row this cycle.
REQ-008 dp_clr  out  1  clears ABFT datapath accumulators.
REQ-009 dp_load  out  1  datapath captures current row.
REQ-010 dp_row  out  2  row index being loaded, 0..3.
REQ-011 dp_error  in  1  datapath checksum-mismatch flag.
REQ-012 dp_sel  out  2  datapath readout row select.
REQ-013 out_valid  out  1  readout row valid on datapath q outputs.
REQ-014 out_ready  in  1  consumer accepts readout row.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 done  out  1  one-cycle pulse at batch end.
REQ-017 fail  out  1  batch ended with uncorrected error; held until next accepted start.
REQ-018 retry_cnt  out  2  reloads used in current batch.
REQ-019 err_total  out  8  checksum errors since reset, saturating.

Function
REQ-020 FSM states IDLE, CLEAR, LOAD, CHECK, READ, DONE; encoding in package.
REQ-021 IDLE: start=1 -> CLEAR; clears fail and retry_cnt; start in other states ignored.
REQ-022 CLEAR: exactly one cycle, dp_clr=1, beat counter=0 -> LOAD.
REQ-023 LOAD: src_ready=1; dp_load = src_valid & src_ready (combinational); dp_row = beat counter; counter increments per accepted beat; src_valid=0 cycles stall with no load.
REQ-024 LOAD: acceptance of beat 3 -> CHECK next cycle; src_ready=0 outside LOAD.
REQ-025 CHECK: lasts CHECK_LAT cycles; dp_error sampled in last CHECK cycle only.
REQ-026 CHECK, dp_error=0 -> READ with dp_sel=0.
REQ-027 CHECK, dp_error=1: err_total += 1 (saturate at 255); retry allowed and retry_cnt<MAX_RETRY -> retry_cnt+1, CLEAR; else fail=1, DONE (READ skipped).
REQ-028 READ: out_valid=1, dp_sel = row counter; advance on out_valid & out_ready; out_ready=0 holds dp_sel stable.
REQ-029 READ: handshake on row 3 -> DONE; dp_sel wraps to 0.
REQ-030 DONE: one cycle, done=1 -> IDLE.
REQ-031 dp_clr, dp_load, out_valid, done mutually exclusive in every cycle.

Reset
REQ-032 rst low: state IDLE immediately, all outputs 0, counters/err_total 0, regardless of state (mid-LOAD/READ included).
REQ-033 First start accepted on first rising edge after rst deasserts.

Configuration
REQ-034 Macro ABFT_RETRY_EN defined: retry path per REQ-027 compiled in.
REQ-035 ABFT_RETRY_EN undefined: any CHECK error -> fail=1, DONE; retry_cnt tied 0; MAX_RETRY ignored.

Structure
REQ-036 Shared package abft_pkg holds FSM state enum, ROWS=4, row index width 2, ERR_CNT_W=8.
REQ-037 One sub-module abft_beat_cnt: 2-bit counter with clear, enable, terminal flag; instantiated twice (load beats, readout rows).

Verification
REQ-038 Clean batch, src_valid always 1, dp_error=0, out_ready=1, CHECK_LAT=1 -> dp_load rows 0..3 cycles 2..5, dp_sel 0..3 cycles 7..10, done cycle 11, fail=0.
REQ-039 src_valid low on beat 1 for 3 cycles -> dp_row holds 1, no dp_load those cycles, total LOAD 7 cycles.
REQ-040 ABFT_RETRY_EN, MAX_RETRY=2, dp_error=1 first check then 0 -> retry_cnt=1, second CLEAR pulse, readout completes, fail=0, err_total=1.
REQ-041 ABFT_RETRY_EN, dp_error always 1 -> 3 checks, retry_cnt=2, fail=1, no out_valid, err_total=3; without macro -> 1 check, fail=1.
REQ-042 out_ready=0 during row 2 for 4 cycles -> dp_sel=2 held, out_valid=1, done delayed 4 cycles.
REQ-043 rst asserted mid-READ (row 1) -> same cycle all outputs 0, busy=0; err_total 0; new start runs clean batch.
